// File: rtl/console_pkg.sv
// Shared constants, state encoding and row arithmetic for the text console writer.
package console_pkg;

  localparam int unsigned COLS_DEF = 80;
  localparam int unsigned ROWS_DEF = 30;

  localparam logic [7:0] CC_BS      = 8'h08;
  localparam logic [7:0] CC_LF      = 8'h0A;
  localparam logic [7:0] CC_FF      = 8'h0C;
  localparam logic [7:0] CC_CR      = 8'h0D;
  localparam logic [7:0] CHAR_BLANK = 8'h20;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_LINECLR = 2'd2
  } state_e;

  // (a + b) mod n for a, b < n: a single compare/subtract instead of a divider.
  function automatic logic [4:0] wrap_add(input logic [4:0] a, input logic [4:0] b,
                                          input int unsigned n);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'(n)) s = s - 6'(n);
    return s[4:0];
  endfunction

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/console_row_clearer.sv
// Emits count_i consecutive blank-cell write strobes starting at base_i, one per cycle.
module console_row_clearer #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] count_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              last_o
);

  logic              active_q, active_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] left_q, left_d;

  // left_q counts the writes still to come after the one currently on the outputs.
  always_comb begin
    active_d = active_q;
    addr_d   = addr_q;
    left_d   = left_q;
    if (start_i) begin
      active_d = 1'b1;
      addr_d   = base_i;
      left_d   = count_i - ADDR_W'(1);
    end else if (active_q) begin
      if (left_q == '0) begin
        active_d = 1'b0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
        left_d = left_q - ADDR_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      addr_q   <= '0;
      left_q   <= '0;
    end else begin
      active_q <= active_d;
      addr_q   <= addr_d;
      left_q   <= left_d;
    end
  end

  assign wr_en_o   = active_q;
  assign wr_addr_o = addr_q;
  assign last_o    = active_q && (left_q == '0);

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream writer for the text-mode character memory: cursor, control codes,
// line wrap and pointer-based scrolling.
module text_console_writer
  import console_pkg::*;
#(
  parameter int unsigned COLS         = COLS_DEF,
  parameter int unsigned ROWS         = ROWS_DEF,
  parameter logic [7:0]  DEFAULT_ATTR = 8'h07,
  parameter int unsigned ADDR_W       = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        IN_CHAR,
  input  logic [7:0]        IN_ATTR,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_CHAR,
  output logic [7:0]        WR_ATTR,
  output logic [6:0]        CUR_COL,
  output logic [4:0]        CUR_ROW,
  output logic [4:0]        TOP_ROW
);

  state_e            state_q, state_d;
  logic [6:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic [4:0]        top_q, top_d;
  logic              pend_q, pend_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_char_q, wr_char_d;
  logic [7:0]        wr_attr_q, wr_attr_d;

  logic              clr_start;
  logic [ADDR_W-1:0] clr_base, clr_count;
  logic              clr_en, clr_last;
  logic [ADDR_W-1:0] clr_addr;
  logic [4:0]        phys_row;
  logic [ADDR_W-1:0] cur_addr;
  logic              newline;

  assign phys_row = wrap_add(row_q, top_q, ROWS);
  assign cur_addr = ADDR_W'(phys_row) * ADDR_W'(COLS) + ADDR_W'(col_q);

  // pend_q defers a clear by one cycle: after reset/FF, and when a printable's own
  // write must go out before the scroll clear starts.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    top_d     = top_q;
    pend_d    = pend_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_char_d = wr_char_q;
    wr_attr_d = wr_attr_q;
    clr_start = 1'b0;
    clr_base  = ADDR_W'(top_q) * ADDR_W'(COLS);
    clr_count = ADDR_W'(COLS);
    newline   = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        if (pend_q) begin
          clr_start = 1'b1;
          clr_base  = '0;
          clr_count = ADDR_W'(COLS * ROWS);
          pend_d    = 1'b0;
        end else if (clr_last) begin
          state_d = ST_IDLE;
          col_d   = '0;
          row_d   = '0;
          top_d   = '0;
        end
      end

      ST_LINECLR: begin
        if (pend_q) begin
          clr_start = 1'b1;
          top_d     = wrap_add(top_q, 5'd1, ROWS);
          pend_d    = 1'b0;
        end else if (clr_last) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        if (IN_VALID) begin
          if (is_printable(IN_CHAR)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr;
            wr_char_d = IN_CHAR;
            wr_attr_d = IN_ATTR;
            if (col_q == 7'(COLS - 1)) begin
              col_d   = '0;
              newline = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else begin
            case (IN_CHAR)
              CC_LF: begin
                col_d   = '0;
                newline = 1'b1;
              end
              CC_CR: col_d = '0;
              CC_BS: if (col_q != '0) col_d = col_q - 7'd1;
              CC_FF: begin
                state_d = ST_CLEAR;
                pend_d  = 1'b1;
              end
              default: ;
            endcase
          end

          if (newline) begin
            if (row_q != 5'(ROWS - 1)) begin
              row_d = row_q + 5'd1;
            end else begin
              state_d = ST_LINECLR;
              if (wr_en_d) begin
                pend_d = 1'b1;
              end else begin
                clr_start = 1'b1;
                top_d     = wrap_add(top_q, 5'd1, ROWS);
              end
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_CLEAR;
      col_q     <= '0;
      row_q     <= '0;
      top_q     <= '0;
      pend_q    <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_char_q <= '0;
      wr_attr_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      top_q     <= top_d;
      pend_q    <= pend_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_char_q <= wr_char_d;
      wr_attr_q <= wr_attr_d;
    end
  end

  console_row_clearer #(.ADDR_W(ADDR_W)) u_clearer (
    .clk_i     (CLK),
    .rst_i     (RST),
    .start_i   (clr_start),
    .base_i    (clr_base),
    .count_i   (clr_count),
    .wr_en_o   (clr_en),
    .wr_addr_o (clr_addr),
    .last_o    (clr_last)
  );

  // The clearer and the printable path never overlap, so a plain mux suffices.
  assign IN_READY = (state_q == ST_IDLE);
  assign WR_EN    = clr_en | wr_en_q;
  assign WR_ADDR  = clr_en ? clr_addr : wr_addr_q;
  assign WR_CHAR  = clr_en ? CHAR_BLANK : wr_char_q;
  assign WR_ATTR  = clr_en ? DEFAULT_ATTR : wr_attr_q;
  assign CUR_COL  = col_q;
  assign CUR_ROW  = row_q;
  assign TOP_ROW  = top_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: clears, printable/control decode, scrolling, reset abort.
module tb_text_console_writer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  IN_CHAR = 8'h00;
  logic [7:0]  IN_ATTR = 8'h00;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic        WR_EN;
  logic [11:0] WR_ADDR;
  logic [7:0]  WR_CHAR;
  logic [7:0]  WR_ATTR;
  logic [6:0]  CUR_COL;
  logic [4:0]  CUR_ROW;
  logic [4:0]  TOP_ROW;

  int checks = 0;
  int errors = 0;
  int top_m  = 0;

  text_console_writer dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_CHAR  (IN_CHAR),
    .IN_ATTR  (IN_ATTR),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .WR_EN    (WR_EN),
    .WR_ADDR  (WR_ADDR),
    .WR_CHAR  (WR_CHAR),
    .WR_ATTR  (WR_ATTR),
    .CUR_COL  (CUR_COL),
    .CUR_ROW  (CUR_ROW),
    .TOP_ROW  (TOP_ROW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] ch;
    logic [7:0] at;
    logic       en;
    int         addr;
    int         col;
    int         row;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a);
    IN_CHAR  = c;
    IN_ATTR  = a;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic run_clear(input string tag);
    int n = 0;
    int bad = 0;
    int last = -1;
    int rdy = -1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (WR_EN) begin
        if (WR_ADDR != 12'(n) || WR_CHAR != 8'h20 || WR_ATTR != 8'h07 || IN_READY) bad++;
        n++;
        last = c;
      end
      if (IN_READY) begin
        rdy = c;
        break;
      end
    end
    check({tag, "_write_count"}, n, 2400);
    check({tag, "_bad_writes"}, bad, 0);
    check({tag, "_ready_after_last"}, rdy, last + 1);
    check({tag, "_cur_col"}, CUR_COL, 0);
    check({tag, "_cur_row"}, CUR_ROW, 0);
    check({tag, "_top_row"}, TOP_ROW, 0);
    top_m = 0;
  endtask

  // Called in the first cycle after the scroll was triggered; checks the 80-cell blank run.
  task automatic scroll_wait(input string tag, input int base);
    int n = 0;
    int bad = 0;
    int low = 0;
    for (int c = 0; c < 200; c++) begin
      if (IN_READY) break;
      low++;
      if (WR_EN) begin
        if (WR_ADDR != 12'(base + n) || WR_CHAR != 8'h20 || WR_ATTR != 8'h07) bad++;
        n++;
      end
      tick();
    end
    check({tag, "_ready_low"}, low, 80);
    check({tag, "_writes"}, n, 80);
    check({tag, "_bad"}, bad, 0);
    check({tag, "_top"}, TOP_ROW, top_m);
    check({tag, "_row"}, CUR_ROW, 29);
    check({tag, "_col"}, CUR_COL, 0);
  endtask

  task automatic scroll_lf(input string tag);
    int base;
    base  = top_m * 80;
    top_m = (top_m + 1) % 30;
    send(8'h0A, 8'h00);
    scroll_wait(tag, base);
  endtask

  initial begin
    int bad;
    int base;

    vecs[0]  = '{8'h08, 8'h00, 1'b0, 0,   0, 1};
    vecs[1]  = '{8'h78, 8'h2F, 1'b1, 80,  1, 1};
    vecs[2]  = '{8'h79, 8'h30, 1'b1, 81,  2, 1};
    vecs[3]  = '{8'h08, 8'h00, 1'b0, 0,   1, 1};
    vecs[4]  = '{8'h59, 8'h31, 1'b1, 81,  2, 1};
    vecs[5]  = '{8'h0D, 8'h00, 1'b0, 0,   0, 1};
    vecs[6]  = '{8'h0A, 8'h00, 1'b0, 0,   0, 2};
    vecs[7]  = '{8'h7A, 8'h44, 1'b1, 160, 1, 2};
    vecs[8]  = '{8'h00, 8'h00, 1'b0, 0,   1, 2};
    vecs[9]  = '{8'h7F, 8'h00, 1'b0, 0,   1, 2};
    vecs[10] = '{8'h7E, 8'h55, 1'b1, 161, 2, 2};
    vecs[11] = '{8'h1F, 8'h00, 1'b0, 0,   2, 2};
    vecs[12] = '{8'h20, 8'h11, 1'b1, 162, 3, 2};
    vecs[13] = '{8'h0B, 8'h00, 1'b0, 0,   3, 2};

    // Reset state, then the power-on clear.
    tick();
    tick();
    check("rst_wr_en", WR_EN, 0);
    check("rst_in_ready", IN_READY, 0);
    check("rst_wr_addr", WR_ADDR, 0);
    check("rst_top", TOP_ROW, 0);
    RST = 1'b0;
    run_clear("por_clear");

    // First printable.
    send(8'h41, 8'h1E);
    check("a_wr_en", WR_EN, 1);
    check("a_wr_addr", WR_ADDR, 0);
    check("a_wr_char", WR_CHAR, 8'h41);
    check("a_wr_attr", WR_ATTR, 8'h1E);
    check("a_cur_col", CUR_COL, 1);
    send(8'h08, 8'h00);
    check("bs_to_col0", CUR_COL, 0);

    // 80 back-to-back printables wrap onto row 1.
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      send(8'h30 + 8'(i % 10), 8'h07);
      if (!WR_EN || WR_ADDR != 12'(i) || WR_CHAR != 8'h30 + 8'(i % 10)) bad++;
    end
    check("line80_bad", bad, 0);
    check("line80_col", CUR_COL, 0);
    check("line80_row", CUR_ROW, 1);

    // Table of single-byte decode cases from (row 1, col 0).
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].ch, vecs[i].at);
      check($sformatf("vec%0d_en", i), WR_EN, vecs[i].en);
      if (vecs[i].en) begin
        check($sformatf("vec%0d_addr", i), WR_ADDR, vecs[i].addr);
        check($sformatf("vec%0d_char", i), WR_CHAR, vecs[i].ch);
        check($sformatf("vec%0d_attr", i), WR_ATTR, vecs[i].at);
      end
      check($sformatf("vec%0d_col", i), CUR_COL, vecs[i].col);
      check($sformatf("vec%0d_row", i), CUR_ROW, vecs[i].row);
    end

    // CR from col 5 writes nothing.
    send(8'h61, 8'h07);
    send(8'h62, 8'h07);
    check("pre_cr_col", CUR_COL, 5);
    send(8'h0D, 8'h00);
    check("cr_wr_en", WR_EN, 0);
    check("cr_col", CUR_COL, 0);

    // Walk to the bottom row, then scroll with LF.
    for (int i = 0; i < 27; i++) send(8'h0A, 8'h00);
    check("bottom_row", CUR_ROW, 29);
    check("bottom_top", TOP_ROW, 0);
    scroll_lf("lf_scroll0");
    send(8'h42, 8'h07);
    check("b_wr_addr", WR_ADDR, 0);
    check("b_wr_char", WR_CHAR, 8'h42);
    check("b_col", CUR_COL, 1);

    // Printable in the last cell: own write first, then the line clear.
    for (int i = 0; i < 78; i++) send(8'h63, 8'h07);
    check("last_cell_col", CUR_COL, 79);
    send(8'h44, 8'h4E);
    check("wrap_wr_en", WR_EN, 1);
    check("wrap_wr_addr", WR_ADDR, 79);
    check("wrap_wr_char", WR_CHAR, 8'h44);
    check("wrap_wr_attr", WR_ATTR, 8'h4E);
    check("wrap_ready", IN_READY, 0);
    tick();
    base  = top_m * 80;
    top_m = (top_m + 1) % 30;
    scroll_wait("wrap_scroll", base);

    // Scroll until TOP_ROW wraps 29 -> 0.
    for (int i = 0; i < 28; i++) scroll_lf($sformatf("scroll%0d", i + 2));
    check("top_wrapped", TOP_ROW, 0);
    scroll_lf("scroll_post_wrap");
    check("top_before_ff", TOP_ROW, 1);

    // Form feed: full clear, cursor home, TOP_ROW 0.
    send(8'h0C, 8'h00);
    check("ff_ready_drop", IN_READY, 0);
    run_clear("ff_clear");

    // Reset in the middle of a line clear.
    for (int i = 0; i < 29; i++) send(8'h0A, 8'h00);
    check("abort_row", CUR_ROW, 29);
    send(8'h0A, 8'h00);
    repeat (10) tick();
    check("abort_in_lineclr", WR_EN, 1);
    RST = 1'b1;
    #1;
    check("abort_wr_en", WR_EN, 0);
    check("abort_in_ready", IN_READY, 0);
    check("abort_top", TOP_ROW, 0);
    check("abort_row_rst", CUR_ROW, 0);
    tick();
    RST = 1'b0;
    run_clear("abort_clear");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
